parity_frame_unit: RTL and testbench



---
 rtl/parity_frame_unit.sv | 99 +++++++++
 tb/tb_parity_frame_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_unit.sv
// Frame parity unit: folds FRAME_LEN words into one parity bit over a valid/ready stream.
// In check mode it compares that bit against a supplied parity and keeps a saturating count of mismatches.
module parity_frame_unit #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int              CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic            ODD_BIT = (ODD != 0);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_acc;
  logic             r_frame_mode;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_first;
  logic w_last;
  logic w_word_par;
  logic w_parity;
  logic w_mode_eff;
  logic w_err;

  assign in_ready   = (r_state == ST_ACCUM);
  assign out_valid  = (r_state == ST_RESULT);
  assign busy       = (r_cnt != '0) || out_valid;

  assign w_accept   = in_valid && in_ready;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == LAST);
  assign w_word_par = ^in_data;
  assign w_parity   = r_acc ^ w_word_par ^ ODD_BIT;
  // A one-word frame has no earlier edge to latch mode on, so the live input is used.
  assign w_mode_eff = w_first ? mode : r_frame_mode;
  assign w_err      = w_mode_eff && (w_parity != in_par);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_accept && w_last) w_state_next = ST_RESULT;
      ST_RESULT: if (out_ready)          w_state_next = ST_ACCUM;
      default:                           w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_frame_mode <= 1'b0;
      out_parity   <= 1'b0;
      out_err      <= 1'b0;
      err_count    <= '0;
    end else if (w_accept) begin
      if (w_first) r_frame_mode <= mode;
      if (w_last) begin
        r_acc      <= 1'b0;
        r_cnt      <= '0;
        out_parity <= w_parity;
        out_err    <= w_err;
        if (w_err && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      end else begin
        r_acc <= r_acc ^ w_word_par;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_unit.sv
// Self-checking bench: a default instance and an ODD=1/ERR_W=2 twin share one stimulus stream and are
// compared every cycle with a frame-level model; a WIDTH=3/FRAME_LEN=1 instance sweeps the 3-input truth table.
module tb_parity_frame_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mode, in_valid, in_par, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, a_out_parity, a_out_err, a_busy;
  logic [7:0] a_err_count;
  logic       b_in_ready, b_out_valid, b_out_parity, b_out_err, b_busy;
  logic [1:0] b_err_count;

  logic       f_mode, f_valid, f_par, f_out_ready;
  logic [2:0] f_data;
  logic       f_in_ready, f_out_valid, f_out_parity, f_out_err, f_busy;
  logic [7:0] f_err_count;

  parity_frame_unit #(.WIDTH(8), .FRAME_LEN(4), .ODD(0), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_parity(a_out_parity), .out_err(a_out_err), .err_count(a_err_count), .busy(a_busy));

  parity_frame_unit #(.WIDTH(8), .FRAME_LEN(4), .ODD(1), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_parity(b_out_parity), .out_err(b_out_err), .err_count(b_err_count), .busy(b_busy));

  parity_frame_unit #(.WIDTH(3), .FRAME_LEN(1), .ODD(0), .ERR_W(8)) u_dut_f (
    .clk(clk), .rst(rst), .mode(f_mode), .in_valid(f_valid), .in_ready(f_in_ready),
    .in_data(f_data), .in_par(f_par), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_parity(f_out_parity), .out_err(f_out_err), .err_count(f_err_count), .busy(f_busy));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect accepted words, then compute parity from total set-bit count.
  logic [7:0] m_words[$];
  bit m_pend, m_fmode, m_par_a, m_err_a, m_par_b, m_err_b;
  int m_cnt_a, m_cnt_b;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_words.delete();
      m_pend = 0; m_fmode = 0;
      m_par_a = 0; m_err_a = 0; m_par_b = 0; m_err_b = 0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 0;
    end else if (in_valid) begin
      int ones;
      if (m_words.size() == 0) m_fmode = mode;
      m_words.push_back(in_data);
      if (m_words.size() == 4) begin
        ones = 0;
        foreach (m_words[i]) ones += $countones(m_words[i]);
        m_par_a = (ones % 2) == 1;
        m_par_b = !m_par_a;
        m_err_a = m_fmode && (m_par_a != in_par);
        m_err_b = m_fmode && (m_par_b != in_par);
        if (m_err_a && m_cnt_a < 255) m_cnt_a++;
        if (m_err_b && m_cnt_b < 3)   m_cnt_b++;
        m_words.delete();
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_in_ready",  a_in_ready,  !m_pend);
      check("a_out_valid", a_out_valid, m_pend);
      check("a_busy",      a_busy,      m_pend || (m_words.size() != 0));
      check("a_err_count", a_err_count, m_cnt_a);
      check("b_in_ready",  b_in_ready,  !m_pend);
      check("b_out_valid", b_out_valid, m_pend);
      check("b_busy",      b_busy,      m_pend || (m_words.size() != 0));
      check("b_err_count", b_err_count, m_cnt_b);
      if (m_pend) begin
        check("a_out_parity", a_out_parity, m_par_a);
        check("a_out_err",    a_out_err,    m_err_a);
        check("b_out_parity", b_out_parity, m_par_b);
        check("b_out_err",    b_out_err,    m_err_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic md, input logic p, input int gap);
    int n;
    n = 0;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = d; mode = md; in_par = p;
    while (!a_in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("accept_timeout", 1'b1, 1'b0);
    tick();
    in_valid = 1'b0; in_data = 8'($urandom); mode = 1'($urandom); in_par = 1'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] w0, w1, w2, w3, input logic md, input logic p);
    send_word(w0, md, 1'($urandom), 0);
    send_word(w1, md, 1'($urandom), 0);
    send_word(w2, md, 1'($urandom), 0);
    send_word(w3, md, p, 0);
  endtask

  task automatic release_result(input int hold);
    int n;
    n = 0;
    while (!a_out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) check("result_timeout", 1'b1, 1'b0);
    repeat (hold) begin
      in_valid = 1'($urandom); in_data = 8'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    bit exp_f[8];
    logic [1:0] exp_sat[5];
    logic [2:0] d3;
    exp_f   = '{0, 1, 1, 0, 1, 0, 0, 1};
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; mode = 0; in_valid = 0; in_par = 0; out_ready = 0; in_data = '0;
    f_mode = 0; f_valid = 0; f_par = 0; f_out_ready = 0; f_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    check("rst_in_ready",   a_in_ready,   1);
    check("rst_out_valid",  a_out_valid,  0);
    check("rst_out_parity", a_out_parity, 0);
    check("rst_out_err",    a_out_err,    0);
    check("rst_err_count",  a_err_count,  0);
    check("rst_busy",       a_busy,       0);

    // Generate mode: 1+2+0+8 set bits is odd.
    send_frame(8'h01, 8'h03, 8'h00, 8'hFF, 1'b0, 1'b0);
    check("gen_latency_valid", a_out_valid,  1);
    check("gen_parity_even",   a_out_parity, 1);
    check("gen_err",           a_out_err,    0);
    check("gen_parity_odd",    b_out_parity, 0);
    release_result(0);

    // Check mode: matching then mismatching in_par.
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("chk_match_err",   a_out_err,   0);
    check("chk_match_count", a_err_count, 0);
    release_result(1);
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    check("chk_mismatch_err",   a_out_err,   1);
    check("chk_mismatch_count", a_err_count, 1);
    release_result(0);

    // Mode is latched on the first word only.
    send_word(8'h03, 1'b1, 1'b0, 0);
    send_word(8'h00, 1'b0, 1'b0, 1);
    send_word(8'h00, 1'b0, 1'b0, 0);
    send_word(8'h00, 1'b0, 1'b1, 2);
    check("mode_latch_err", a_out_err, 1);
    release_result(0);

    // Backpressure: result held, input blocked.
    send_frame(8'hAA, 8'h55, 8'h0F, 8'hF0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h01;
    repeat (5) begin
      tick();
      check("bp_out_valid", a_out_valid,  1);
      check("bp_in_ready",  a_in_ready,   0);
      check("bp_parity",    a_out_parity, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", a_out_valid, 0);
    check("bp_release_ready", a_in_ready,  1);
    check("bp_release_busy",  a_busy,      0);

    // Reset mid-frame discards the partial frame.
    send_word(8'h01, 1'b0, 1'b0, 0);
    send_word(8'h01, 1'b0, 1'b0, 0);
    check("mid_busy", a_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",  a_busy,      0);
    check("mid_rst_count", a_err_count, 0);
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("mid_rst_parity", a_out_parity, 1);
    release_result(0);

    // Saturation on the 2-bit counter of the odd-parity twin.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      check("sat_err",   b_out_err,   1);
      check("sat_count", b_err_count, exp_sat[i]);
      release_result(0);
    end

    // Randomized frames with gaps, mid-frame mode noise and backpressure.
    for (int fr = 0; fr < 40; fr++) begin
      for (int w = 0; w < 4; w++)
        send_word(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      release_result(int'($urandom_range(0, 3)));
    end

    // FRAME_LEN=1 truth-table sweep.
    f_out_ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      d3 = 3'(d);
      check("f1_in_ready", f_in_ready, 1);
      f_valid = 1'b1; f_data = d3;
      tick();
      f_valid = 1'b0;
      check("f1_out_valid", f_out_valid,  1);
      check("f1_parity",    f_out_parity, exp_f[d]);
      check("f1_err",       f_out_err,    0);
      check("f1_busy",      f_busy,       1);
      tick();
      check("f1_release", f_out_valid, 0);
    end
    check("f1_err_count", f_err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
